// File: rtl/cla_seq_pkg.sv
// rtl/cla_seq_pkg.sv - shared types and helpers for the nibble-serial CLA adder
package cla_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nibbles(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// rtl/cla4_slice.sv - combinational 4-bit carry-lookahead slice with group generate/propagate
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0,
    output logic [3:0] s,
    output logic       g,
    output logic       p
);

    logic [3:0] gi;
    logic [3:0] pi;
    logic [3:0] c;

    assign gi = a & b;
    assign pi = a ^ b;

    // Internal carries are expanded directly from c0 so no ripple path exists inside the slice.
    assign c[0] = c0;
    assign c[1] = gi[0] | (pi[0] & c0);
    assign c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & c0);
    assign c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
                | (pi[2] & pi[1] & pi[0] & c0);

    assign s = pi ^ c;

    // Group terms exclude c0; the caller forms carry-out as g | (p & c0).
    assign g = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
             | (pi[3] & pi[2] & pi[1] & gi[0]);
    assign p = &pi;

endmodule

// File: rtl/cla4_seq_adder_ctrl.sv
// rtl/cla4_seq_adder_ctrl.sv - nibble-serial adder sequencing one CLA slice with valid/ready handshakes
module cla4_seq_adder_ctrl
    import cla_seq_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int APPROX_NIBBLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NIB   = nibbles(WIDTH);
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int LSB_W = IDX_W + 2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [IDX_W-1:0] idx;

    logic [LSB_W-1:0]    nib_lsb;
    logic [NIBBLE_W-1:0] slice_a;
    logic [NIBBLE_W-1:0] slice_b;
    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_g;
    logic                slice_p;
    logic                carry_raw;
    logic                carry_next;

    // Bit offset of the active nibble: idx * 4.
    assign nib_lsb = {idx, 2'b00};
    assign slice_a = a_reg[nib_lsb +: NIBBLE_W];
    assign slice_b = b_reg[nib_lsb +: NIBBLE_W];

    cla4_slice u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .c0 (carry),
        .s  (slice_s),
        .g  (slice_g),
        .p  (slice_p)
    );

    assign carry_raw = slice_g | (slice_p & carry);

    // Low nibbles inside the approximate region never pass a carry upward.
    always_comb begin
        carry_next = carry_raw;
        if (int'(idx) < APPROX_NIBBLES) begin
            carry_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            idx       <= '0;
            carry     <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        carry    <= cin;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum[nib_lsb +: NIBBLE_W] <= slice_s;
                    if (idx == LAST_IDX) begin
                        cout      <= carry_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        carry <= carry_next;
                    end
                end
                DONE: begin
                    // in_ready rises only after this edge, so accept never coincides with the out handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
